tri_mat_row_server: RTL and testbench

Row store directly upstream of the triangular matrix inverse engine. It captures a SIZE×SIZE complex lower-triangular matrix row by row from the load port and then serves it to the inverse engine's row-request port. Each served row is returned with its address, one cycle after the request. It pulses `start_o` when the matrix is complete, and holds the data until the consumer releases it.

---
 rtl/tri_mat_row_server_pkg.sv | 24 ++
 rtl/tri_mat_row_server_if.sv | 34 +++
 rtl/tri_mat_row_server_cplx_row_mem.sv | 37 +++
 rtl/tri_mat_row_server.sv | 114 +++++++++++
 tb/tb_tri_mat_row_server.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/tri_mat_row_server_pkg.sv
// Shared types for the triangular-matrix row store: complex element, FSM states, zero test.
package tri_mat_row_server_pkg;

  localparam int unsigned FP_W = 64;

  typedef struct packed {
    logic [FP_W-1:0] im;
    logic [FP_W-1:0] re;
  } cplx_t;

  localparam cplx_t CPLX_ZERO = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } srv_state_t;

  // Sign bits are ignored so that +0.0 and -0.0 both count as zero.
  function automatic logic cplx_is_zero(input cplx_t c);
    return (c.re[FP_W-2:0] == '0) && (c.im[FP_W-2:0] == '0);
  endfunction

endpackage

// File: rtl/tri_mat_row_server_if.sv
// Load, request/response and control signals between the row store and its neighbours.
interface tri_mat_row_server_if
  import tri_mat_row_server_pkg::*;
#(
  parameter int unsigned SIZE = 16
);
  localparam int unsigned AW = $clog2(SIZE);

  logic                 flush_i;
  cplx_t [SIZE-1:0]     ld_row_i;
  logic [AW-1:0]        ld_addr_i;
  logic                 ld_valid_i;
  logic                 ld_ready_o;
  logic [AW-1:0]        req_addr_i;
  logic                 req_valid_i;
  cplx_t [SIZE-1:0]     row_o;
  logic [AW-1:0]        row_addr_o;
  logic                 row_valid_o;
  logic                 start_o;
  logic                 release_i;
  logic                 singular_o;
  logic                 busy_o;

  modport slave (
    input  flush_i, ld_row_i, ld_addr_i, ld_valid_i, req_addr_i, req_valid_i, release_i,
    output ld_ready_o, row_o, row_addr_o, row_valid_o, start_o, singular_o, busy_o
  );

  modport master (
    output flush_i, ld_row_i, ld_addr_i, ld_valid_i, req_addr_i, req_valid_i, release_i,
    input  ld_ready_o, row_o, row_addr_o, row_valid_o, start_o, singular_o, busy_o
  );

endinterface

// File: rtl/tri_mat_row_server_cplx_row_mem.sv
// SIZE-deep row array: one write port that zeroes the strict upper triangle, one registered read port.
module cplx_row_mem
  import tri_mat_row_server_pkg::*;
#(
  parameter int unsigned SIZE = 16,
  localparam int unsigned AW = $clog2(SIZE)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  cplx_t [SIZE-1:0] wr_row,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output cplx_t [SIZE-1:0] rd_row
);

  cplx_t [SIZE-1:0] store [SIZE];

  // Storage carries no reset; contents are undefined until written.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int j = 0; j < int'(SIZE); j++) begin
        store[wr_addr][j] <= (AW'(j) > wr_addr) ? CPLX_ZERO : wr_row[j];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_row <= '0;
    end else if (rd_en) begin
      rd_row <= store[rd_addr];
    end
  end

endmodule

// File: rtl/tri_mat_row_server.sv
// Captures a lower-triangular complex matrix row by row, then serves rows to the inverse engine.
module tri_mat_row_server
  import tri_mat_row_server_pkg::*;
#(
  parameter int unsigned SIZE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tri_mat_row_server_if.slave  bus
);

  localparam int unsigned AW = $clog2(SIZE);

  srv_state_t    state_q, state_d;
  logic [SIZE-1:0] mask_q, mask_d;
  logic          singular_q, singular_d;
  logic          start_q, start_d;
  logic          row_valid_q, row_valid_d;
  logic [AW-1:0] row_addr_q, row_addr_d;
  logic          wr_en, rd_en;
  logic [SIZE-1:0] ld_onehot;
  logic          diag_zero;

  assign ld_onehot = SIZE'(1) << bus.ld_addr_i;
  assign diag_zero = cplx_is_zero(bus.ld_row_i[bus.ld_addr_i]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      mask_q      <= '0;
      singular_q  <= 1'b0;
      start_q     <= 1'b0;
      row_valid_q <= 1'b0;
      row_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      singular_q  <= singular_d;
      start_q     <= start_d;
      row_valid_q <= row_valid_d;
      row_addr_q  <= row_addr_d;
    end
  end

  // Flush outranks everything; release outranks a same-cycle request.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    singular_d  = singular_q;
    start_d     = 1'b0;
    row_valid_d = 1'b0;
    row_addr_d  = row_addr_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    if (bus.flush_i) begin
      state_d    = EMPTY;
      mask_d     = '0;
      singular_d = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (bus.ld_valid_i) begin
            wr_en      = 1'b1;
            mask_d     = ld_onehot;
            singular_d = diag_zero;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          if (bus.ld_valid_i) begin
            wr_en      = 1'b1;
            mask_d     = mask_q | ld_onehot;
            singular_d = singular_q | diag_zero;
            if (&(mask_q | ld_onehot)) begin
              state_d = SERVE;
              start_d = 1'b1;
            end
          end
        end
        SERVE: begin
          if (bus.release_i) begin
            state_d    = EMPTY;
            mask_d     = '0;
            singular_d = 1'b0;
          end else if (bus.req_valid_i) begin
            rd_en       = 1'b1;
            row_valid_d = 1'b1;
            row_addr_d  = bus.req_addr_i;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  cplx_row_mem #(.SIZE(SIZE)) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_en   (wr_en),
    .wr_addr (bus.ld_addr_i),
    .wr_row  (bus.ld_row_i),
    .rd_en   (rd_en),
    .rd_addr (bus.req_addr_i),
    .rd_row  (bus.row_o)
  );

  assign bus.ld_ready_o  = (state_q != SERVE);
  assign bus.busy_o      = (state_q != EMPTY);
  assign bus.row_valid_o = row_valid_q;
  assign bus.row_addr_o  = row_addr_q;
  assign bus.start_o     = start_q;
  assign bus.singular_o  = singular_q;

endmodule

// File: tb/tb_tri_mat_row_server.sv
// Directed bench for tri_mat_row_server at SIZE=8 with immediate-assertion checks.
module tb_tri_mat_row_server;
  import tri_mat_row_server_pkg::*;

  localparam int unsigned SIZE = 8;
  localparam int unsigned AW = $clog2(SIZE);
  localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] NZERO = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tri_mat_row_server_if #(.SIZE(SIZE)) bus ();

  tri_mat_row_server #(.SIZE(SIZE)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one row: every element = val+0i, diagonal real part = diag.
  task automatic load(input int addr, input logic [63:0] val, input logic [63:0] diag);
    for (int j = 0; j < int'(SIZE); j++) bus.ld_row_i[j] = {64'h0, val};
    bus.ld_row_i[addr] = {64'h0, diag};
    bus.ld_addr_i  = AW'(addr);
    bus.ld_valid_i = 1'b1;
    tick();
    bus.ld_valid_i = 1'b0;
  endtask

  task automatic request(input int addr);
    bus.req_addr_i  = AW'(addr);
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  initial begin
    logic [127:0] exp_el;
    bus.flush_i     = 1'b0;
    bus.ld_row_i    = '0;
    bus.ld_addr_i   = '0;
    bus.ld_valid_i  = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_valid_i = 1'b0;
    bus.release_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    chk("rst_ld_ready",  128'(bus.ld_ready_o), 128'd1);
    chk("rst_busy",      128'(bus.busy_o), 128'd0);
    chk("rst_row_valid", 128'(bus.row_valid_o), 128'd0);
    chk("rst_row_addr",  128'(bus.row_addr_o), 128'd0);
    chk("rst_start",     128'(bus.start_o), 128'd0);
    chk("rst_singular",  128'(bus.singular_o), 128'd0);
    chk("rst_row0",      128'(bus.row_o[0]), 128'd0);

    // In-order load of all-ones matrix.
    for (int r = 0; r < int'(SIZE) - 1; r++) load(r, ONE, ONE);
    chk("load_busy",  128'(bus.busy_o), 128'd1);
    chk("load_ready", 128'(bus.ld_ready_o), 128'd1);
    chk("load_start", 128'(bus.start_o), 128'd0);
    load(SIZE - 1, ONE, ONE);
    chk("serve_start",    128'(bus.start_o), 128'd1);
    chk("serve_ld_ready", 128'(bus.ld_ready_o), 128'd0);
    chk("serve_sing",     128'(bus.singular_o), 128'd0);
    tick();
    chk("start_pulse_end", 128'(bus.start_o), 128'd0);

    request(1);
    chk("r1_valid", 128'(bus.row_valid_o), 128'd1);
    chk("r1_addr",  128'(bus.row_addr_o), 128'd1);
    for (int j = 0; j < int'(SIZE); j++) begin
      exp_el = (j <= 1) ? {64'h0, ONE} : 128'h0;
      chk($sformatf("r1_el%0d", j), bus.row_o[j], exp_el);
    end
    tick();
    chk("r1_valid_drop", 128'(bus.row_valid_o), 128'd0);

    bus.release_i = 1'b1;
    tick();
    bus.release_i = 1'b0;
    chk("rel_busy",  128'(bus.busy_o), 128'd0);
    chk("rel_ready", 128'(bus.ld_ready_o), 128'd1);

    // Out-of-order load with an overwrite and a -0.0 diagonal.
    load(7, ONE, ONE);
    load(0, ONE, ONE);
    load(3, ONE, ONE);
    load(4, ONE, ONE);
    load(5, ONE, ONE);
    load(6, ONE, ONE);
    load(7, TWO, TWO);
    chk("ooo_sing_pre", 128'(bus.singular_o), 128'd0);
    load(2, ONE, NZERO);
    chk("ooo_sing",     128'(bus.singular_o), 128'd1);
    chk("ooo_not_yet",  128'(bus.ld_ready_o), 128'd1);
    load(1, ONE, ONE);
    chk("ooo_start",    128'(bus.start_o), 128'd1);
    chk("ooo_ld_ready", 128'(bus.ld_ready_o), 128'd0);
    chk("ooo_sing_srv", 128'(bus.singular_o), 128'd1);

    request(7);
    chk("r7_addr", 128'(bus.row_addr_o), 128'd7);
    for (int j = 0; j < int'(SIZE); j++)
      chk($sformatf("r7_el%0d", j), bus.row_o[j], {64'h0, TWO});

    request(2);
    for (int j = 0; j < int'(SIZE); j++) begin
      exp_el = (j < 2) ? {64'h0, ONE} : (j == 2) ? {64'h0, NZERO} : 128'h0;
      chk($sformatf("r2_el%0d", j), bus.row_o[j], exp_el);
    end

    // Request held five cycles, stepping address.
    bus.req_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.req_addr_i = AW'(k);
      tick();
      chk($sformatf("burst%0d_valid", k), 128'(bus.row_valid_o), 128'd1);
      chk($sformatf("burst%0d_addr", k),  128'(bus.row_addr_o), 128'(k));
    end
    bus.req_valid_i = 1'b0;
    tick();
    chk("burst_end_valid", 128'(bus.row_valid_o), 128'd0);

    // Release wins over a same-cycle request.
    bus.req_addr_i  = AW'(3);
    bus.req_valid_i = 1'b1;
    bus.release_i   = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    bus.release_i   = 1'b0;
    chk("relreq_valid", 128'(bus.row_valid_o), 128'd0);
    chk("relreq_busy",  128'(bus.busy_o), 128'd0);
    chk("relreq_sing",  128'(bus.singular_o), 128'd0);

    // Release outside SERVE is ignored; flush mid-LOAD discards progress.
    load(0, ONE, ONE);
    load(1, ONE, ONE);
    bus.release_i = 1'b1;
    tick();
    bus.release_i = 1'b0;
    chk("rel_in_load_busy", 128'(bus.busy_o), 128'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flush_busy", 128'(bus.busy_o), 128'd0);
    for (int r = 2; r < int'(SIZE); r++) load(r, ONE, ONE);
    chk("flush_need_all", 128'(bus.ld_ready_o), 128'd1);
    load(0, ONE, ONE);
    chk("flush_need_r1", 128'(bus.ld_ready_o), 128'd1);
    load(1, ONE, ONE);
    chk("flush_serve_start", 128'(bus.start_o), 128'd1);

    // Asynchronous reset during a response.
    request(3);
    chk("pre_rst_valid", 128'(bus.row_valid_o), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(bus.row_valid_o), 128'd0);
    chk("async_rst_busy",  128'(bus.busy_o), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 128'(bus.ld_ready_o), 128'd1);
    chk("post_rst_row0",  128'(bus.row_o[0]), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
